// File: rtl/ov7670_cam_model.sv
// ov7670_cam_model: OV7670 camera model - RGB565 test-pattern video stream plus SCCB register slave
module ov7670_cam_model #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK = 288,
  parameter int V_SYNC = 3,
  parameter int V_BACK = 17,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT = 10,
  parameter logic [6:0] I2C_ADDR = 7'h21
) (
  input  logic       xclk,
  input  logic       reset,
  output logic       p_clock,
  output logic       vsync,
  output logic       href,
  output logic [7:0] p_data,
  input  logic       i2c_scl,
  inout  wire        i2c_sda
);
  localparam logic [11:0] LINE_M1 = 12'(2 * H_ACTIVE + H_BLANK - 1);
  localparam logic [11:0] ACT_C = 12'(2 * H_ACTIVE);
  localparam logic [10:0] FRAME_M1 = 11'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);
  localparam logic [10:0] VS_END = 11'(V_SYNC);
  localparam logic [10:0] Y0 = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] Y1 = 11'(V_SYNC + V_BACK + V_ACTIVE);
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RACK} state_t;
  logic pclk_q, pclk_d, vsync_q, vsync_d, href_q, href_d, act, fall, col_end, line_end;
  logic [7:0] pdata_q, pdata_d, hi, lo;
  logic [11:0] col_q, col_d;
  logic [10:0] line_q, line_d;
  logic [15:0] frame_q, frame_d;
  logic [9:0] x;
  logic [8:0] y;
  logic soft_q;
  state_t state_q;
  logic [2:0] scl_sr_q, sda_sr_q;
  logic [3:0] cnt_q;
  logic [7:0] sr_q, sub_q, nxt;
  logic rw_q, mack_q, sda_oe_q;
  logic [7:0] regs_q [256];
  logic start, stop, scl_rise, scl_fall, sda_in, wr, ro;
  function automatic logic [7:0] def(input logic [7:0] a);
    return a == 8'h0A ? 8'h76 : a == 8'h0B ? 8'h73 : a == 8'h1C ? 8'h7F : a == 8'h1D ? 8'hA2 : 8'h00;
  endfunction
  assign x = col_q[10:1];
  assign y = 9'(line_q - Y0);
  assign hi = {x[9:5], y[8:6]};
  assign lo = {y[5:3], x[4:0] ^ y[4:0]};
  always_comb begin
    fall = pclk_q;
    act = line_q >= Y0 && line_q < Y1 && col_q < ACT_C;
    col_end = col_q == LINE_M1;
    line_end = line_q == FRAME_M1;
    pclk_d = ~pclk_q;
    vsync_d = fall ? line_q < VS_END : vsync_q;
    href_d = fall ? act : href_q;
    pdata_d = fall ? (act ? (col_q[0] ? lo : hi) : 8'h00) : pdata_q;
    col_d = soft_q ? 12'd0 : fall ? (col_end ? 12'd0 : col_q + 12'd1) : col_q;
    line_d = soft_q ? 11'd0 : fall && col_end ? (line_end ? 11'd0 : line_q + 11'd1) : line_q;
    frame_d = soft_q ? 16'd0 : fall && col_end && line_end ? frame_q + 16'd1 : frame_q;
  end
  always_ff @(posedge xclk) begin
    if (reset) begin
      pclk_q <= 1'b0;
      vsync_q <= 1'b0;
      href_q <= 1'b0;
      pdata_q <= 8'h00;
      col_q <= 12'd0;
      line_q <= 11'd0;
      frame_q <= 16'd0;
    end else begin
      pclk_q <= pclk_d;
      vsync_q <= vsync_d;
      href_q <= href_d;
      pdata_q <= pdata_d;
      col_q <= col_d;
      line_q <= line_d;
      frame_q <= frame_d;
    end
  end
  assign p_clock = pclk_q;
  assign vsync = vsync_q;
  assign href = href_q;
  assign p_data = pdata_q;
  assign sda_in = sda_sr_q[1];
  assign start = scl_sr_q[1] && scl_sr_q[2] && sda_sr_q[2] && !sda_sr_q[1];
  assign stop = scl_sr_q[1] && scl_sr_q[2] && !sda_sr_q[2] && sda_sr_q[1];
  assign scl_rise = scl_sr_q[1] && !scl_sr_q[2];
  assign scl_fall = !scl_sr_q[1] && scl_sr_q[2];
  assign nxt = sub_q + 8'd1;
  assign wr = scl_fall && state_q == WDATA && cnt_q == 4'd8;
  assign ro = sub_q inside {8'h0A, 8'h0B, 8'h1C, 8'h1D};
  assign i2c_sda = sda_oe_q ? 1'b0 : 1'bz;
  always_ff @(posedge xclk) begin
    scl_sr_q <= reset ? 3'b111 : {scl_sr_q[1:0], i2c_scl};
    sda_sr_q <= reset ? 3'b111 : {sda_sr_q[1:0], i2c_sda};
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      sr_q <= 8'h00;
      sub_q <= 8'h00;
      rw_q <= 1'b0;
      mack_q <= 1'b0;
      sda_oe_q <= 1'b0;
    end else if (start) begin
      state_q <= ADDR;
      cnt_q <= 4'd0;
      sda_oe_q <= 1'b0;
    end else if (stop) begin
      state_q <= IDLE;
      sda_oe_q <= 1'b0;
    end else if (scl_rise) begin
      if (state_q inside {ADDR, SUB, WDATA}) begin
        sr_q <= {sr_q[6:0], sda_in};
        cnt_q <= cnt_q + 4'd1;
      end
      if (state_q == RDATA) cnt_q <= cnt_q + 4'd1;
      if (state_q == RACK) mack_q <= !sda_in;
    end else if (scl_fall) begin
      case (state_q)
        ADDR: if (cnt_q == 4'd8) begin
          state_q <= sr_q[7:1] == I2C_ADDR ? ADDR_ACK : IDLE;
          sda_oe_q <= sr_q[7:1] == I2C_ADDR;
          rw_q <= sr_q[0];
        end
        SUB: if (cnt_q == 4'd8) begin
          sub_q <= sr_q;
          state_q <= SUB_ACK;
          sda_oe_q <= 1'b1;
        end
        WDATA: if (cnt_q == 4'd8) begin
          sub_q <= nxt;
          state_q <= WDATA_ACK;
          sda_oe_q <= 1'b1;
        end
        ADDR_ACK: begin
          cnt_q <= 4'd0;
          sr_q <= regs_q[sub_q];
          sda_oe_q <= rw_q && !regs_q[sub_q][7];
          state_q <= rw_q ? RDATA : SUB;
        end
        SUB_ACK, WDATA_ACK: begin
          cnt_q <= 4'd0;
          sda_oe_q <= 1'b0;
          state_q <= WDATA;
        end
        RDATA: if (cnt_q == 4'd8) begin
          sda_oe_q <= 1'b0;
          state_q <= RACK;
        end else begin
          sr_q <= {sr_q[6:0], 1'b0};
          sda_oe_q <= !sr_q[6];
        end
        RACK: if (mack_q) begin
          sub_q <= nxt;
          sr_q <= regs_q[nxt];
          sda_oe_q <= !regs_q[nxt][7];
          cnt_q <= 4'd0;
          state_q <= RDATA;
        end else begin
          state_q <= IDLE;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge xclk) begin
    soft_q <= !reset && wr && sub_q == 8'h12 && sr_q[7];
    if (reset || soft_q) begin
      for (int i = 0; i < 256; i++) regs_q[i] <= def(8'(i));
    end else if (wr && !ro) begin
      regs_q[sub_q] <= sub_q == 8'h12 ? {1'b0, sr_q[6:0]} : sr_q;
    end
  end
endmodule

// File: tb/tb_ov7670_cam_model.sv
// tb_ov7670_cam_model: directed checks of video timing, pattern bytes and SCCB register access
module tb_ov7670_cam_model;
  localparam int HA = 40, HB = 8, VS = 3, VB = 17, VA = 12, VF = 2;
  localparam int LINE = 2 * HA + HB, FRAME = VS + VB + VA + VF, A = 20 * LINE;
  logic xclk = 1'b0, reset = 1'b1, scl = 1'b1, m_low = 1'b0;
  logic p_clock, vsync, href;
  logic [7:0] p_data;
  wire i2c_sda;
  int tests = 0, fails = 0;
  pullup (i2c_sda);
  assign i2c_sda = m_low ? 1'b0 : 1'bz;
  always #5 xclk = ~xclk;
  ov7670_cam_model #(.H_ACTIVE(HA), .H_BLANK(HB), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF), .I2C_ADDR(7'h21)) dut (
    .xclk(xclk), .reset(reset), .p_clock(p_clock), .vsync(vsync), .href(href), .p_data(p_data),
    .i2c_scl(scl), .i2c_sda(i2c_sda)
  );
  initial begin
    #800000;
    $display("FAIL watchdog: reached %0t, limit 800000", $time);
    $fatal(1);
  end
  task automatic sample();
    @(posedge p_clock);
    #1;
  endtask
  task automatic q();
    repeat (8) @(negedge xclk);
  endtask
  task automatic i2c_start();
    m_low = 1'b0; q(); scl = 1'b1; q(); m_low = 1'b1; q(); scl = 1'b0; q();
  endtask
  task automatic i2c_stop();
    m_low = 1'b1; q(); scl = 1'b1; q(); m_low = 1'b0; q();
  endtask
  task automatic i2c_bit(input logic b, output logic r);
    m_low = !b; q(); scl = 1'b1; q(); r = i2c_sda; q(); scl = 1'b0; q();
  endtask
  task automatic i2c_wr(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], r);
    i2c_bit(1'b1, r);
    ack = !r;
  endtask
  task automatic i2c_rd(input logic m_ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, r);
      d[i] = r;
    end
    i2c_bit(!m_ack, r);
  endtask
  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d, output logic ok);
    logic a0, a1, a2;
    i2c_start(); i2c_wr(8'h42, a0); i2c_wr(a, a1); i2c_wr(d, a2); i2c_stop();
    ok = a0 && a1 && a2;
  endtask
  task automatic rd_reg(input logic [7:0] a, output logic [7:0] d);
    logic k;
    i2c_start(); i2c_wr(8'h42, k); i2c_wr(a, k); i2c_start(); i2c_wr(8'h43, k); i2c_rd(1'b0, d); i2c_stop();
  endtask
  task automatic wait_line20();
    int k = 0;
    while (!vsync && k < 2 * FRAME * LINE) begin sample(); k++; end
    while (!href && k < 2 * FRAME * LINE) begin sample(); k++; end
    tests++;
    if (href !== 1'b1) begin fails++; $display("FAIL wait_href: href %b, want 1", href); end
  endtask
  task automatic test_reset();
    repeat (10) @(negedge xclk);
    tests += 5;
    if (p_clock !== 1'b0) begin fails++; $display("FAIL rst_pclk: got %b want 0", p_clock); end
    if (vsync !== 1'b0) begin fails++; $display("FAIL rst_vsync: got %b want 0", vsync); end
    if (href !== 1'b0) begin fails++; $display("FAIL rst_href: got %b want 0", href); end
    if (p_data !== 8'h00) begin fails++; $display("FAIL rst_pdata: got %h want 00", p_data); end
    if (i2c_sda !== 1'b1) begin fails++; $display("FAIL rst_sda: got %b want released 1", i2c_sda); end
    reset = 1'b0;
  endtask
  task automatic test_video();
    int vs_len = -1, href_at = -1, hcnt = 0;
    logic [7:0] exp;
    logic chk;
    sample();
    tests++;
    if (vsync !== 1'b0) begin fails++; $display("FAIL pre_vsync: got %b want 0", vsync); end
    for (int n = 0; n <= FRAME * LINE; n++) begin
      sample();
      if (!vsync && vs_len < 0) vs_len = n;
      if (href && href_at < 0) href_at = n;
      if (n >= A && n < A + LINE && href) hcnt++;
      chk = 1'b1;
      case (n)
        A, A + 1, A + 2: exp = 8'h00;
        A + 3: exp = 8'h01;
        A + 66: exp = 8'h08;
        A + 67: exp = 8'h01;
        A + 78: exp = 8'h08;
        A + 79: exp = 8'h07;
        28 * LINE + 62: exp = 8'h00;
        28 * LINE + 63: exp = 8'h37;
        31 * LINE: exp = 8'h00;
        31 * LINE + 1: exp = 8'h2B;
        default: chk = 1'b0;
      endcase
      if (chk) begin
        tests++;
        if (p_data !== exp || href !== 1'b1) begin
          fails++;
          $display("FAIL byte_%0d: got href %b data %h, want href 1 data %h", n, href, p_data, exp);
        end
      end
      if (n == A + 80 || n == 32 * LINE + 5) begin
        tests++;
        if (href !== 1'b0 || p_data !== 8'h00) begin
          fails++;
          $display("FAIL blank_%0d: got href %b data %h, want 0 00", n, href, p_data);
        end
      end
      if (n == FRAME * LINE - 2 || n == FRAME * LINE - 1) begin
        tests++;
        if (dut.frame_q !== 16'(n - (FRAME * LINE - 2))) begin
          fails++;
          $display("FAIL frame_cnt_%0d: got %0d want %0d", n, dut.frame_q, n - (FRAME * LINE - 2));
        end
      end
      if (n == FRAME * LINE) begin
        tests++;
        if (vsync !== 1'b1) begin fails++; $display("FAIL frame_wrap_vsync: got %b want 1", vsync); end
      end
    end
    tests += 3;
    if (vs_len != 3 * LINE) begin fails++; $display("FAIL vsync_len: got %0d want %0d", vs_len, 3 * LINE); end
    if (href_at != A) begin fails++; $display("FAIL first_href: got %0d want %0d", href_at, A); end
    if (hcnt != 2 * HA) begin fails++; $display("FAIL href_len: got %0d want %0d", hcnt, 2 * HA); end
  endtask
  task automatic test_id_read();
    logic a0, a1, a2;
    logic [7:0] d0, d1;
    i2c_start(); i2c_wr(8'h42, a0); i2c_wr(8'h0A, a1); i2c_start(); i2c_wr(8'h43, a2);
    i2c_rd(1'b1, d0); i2c_rd(1'b0, d1); i2c_stop();
    tests += 5;
    if (a0 !== 1'b1) begin fails++; $display("FAIL id_ack_addr: got %b want 1", a0); end
    if (a1 !== 1'b1) begin fails++; $display("FAIL id_ack_sub: got %b want 1", a1); end
    if (a2 !== 1'b1) begin fails++; $display("FAIL id_ack_rd: got %b want 1", a2); end
    if (d0 !== 8'h76) begin fails++; $display("FAIL id_pid: got %h want 76", d0); end
    if (d1 !== 8'h73) begin fails++; $display("FAIL id_ver: got %h want 73", d1); end
  endtask
  task automatic test_bad_addr();
    logic a0, a1;
    i2c_start(); i2c_wr(8'h44, a0); i2c_wr(8'h12, a1); i2c_stop();
    tests += 2;
    if (a0 !== 1'b0) begin fails++; $display("FAIL bad_addr_ack: got %b want 0", a0); end
    if (a1 !== 1'b0) begin fails++; $display("FAIL bad_addr_data_ack: got %b want 0", a1); end
  endtask
  task automatic test_ro_write();
    logic ok;
    logic [7:0] d;
    wr_reg(8'h0A, 8'h00, ok);
    rd_reg(8'h0A, d);
    tests += 2;
    if (ok !== 1'b1) begin fails++; $display("FAIL ro_acks: got %b want 1", ok); end
    if (d !== 8'h76) begin fails++; $display("FAIL ro_readback: got %h want 76", d); end
  endtask
  task automatic test_auto_inc();
    logic a0, a1, a2, a3;
    logic [7:0] d0, d1, d2, d3;
    i2c_start(); i2c_wr(8'h42, a0); i2c_wr(8'h30, a1); i2c_wr(8'h11, a2); i2c_wr(8'h22, a3); i2c_stop();
    i2c_start(); i2c_wr(8'h42, a0); i2c_wr(8'h30, a0); i2c_start(); i2c_wr(8'h43, a0);
    i2c_rd(1'b1, d0); i2c_rd(1'b0, d1); i2c_stop();
    i2c_start(); i2c_wr(8'h42, a0); i2c_wr(8'hFF, a0); i2c_wr(8'h5A, a0); i2c_wr(8'hA5, a0); i2c_stop();
    i2c_start(); i2c_wr(8'h42, a0); i2c_wr(8'hFF, a0); i2c_start(); i2c_wr(8'h43, a0);
    i2c_rd(1'b1, d2); i2c_rd(1'b0, d3); i2c_stop();
    tests += 5;
    if ((a1 && a2 && a3) !== 1'b1) begin fails++; $display("FAIL inc_acks: got %b%b%b want 111", a1, a2, a3); end
    if (d0 !== 8'h11) begin fails++; $display("FAIL inc_r30: got %h want 11", d0); end
    if (d1 !== 8'h22) begin fails++; $display("FAIL inc_r31: got %h want 22", d1); end
    if (d2 !== 8'h5A) begin fails++; $display("FAIL wrap_rff: got %h want 5a", d2); end
    if (d3 !== 8'hA5) begin fails++; $display("FAIL wrap_r00: got %h want a5", d3); end
  endtask
  task automatic test_partial();
    logic k;
    logic [7:0] d;
    i2c_start(); i2c_wr(8'h42, k); i2c_wr(8'h40, k);
    for (int i = 0; i < 4; i++) i2c_bit(1'b1, k);
    i2c_stop();
    rd_reg(8'h40, d);
    tests++;
    if (d !== 8'h00) begin fails++; $display("FAIL partial_drop: got %h want 00", d); end
  endtask
  task automatic test_soft_reset();
    logic ok;
    logic [7:0] d;
    int k;
    wr_reg(8'h12, 8'h05, ok);
    rd_reg(8'h12, d);
    tests++;
    if (d !== 8'h05) begin fails++; $display("FAIL com7_store: got %h want 05", d); end
    wait_line20();
    wr_reg(8'h12, 8'h80, ok);
    sample();
    tests += 2;
    if (ok !== 1'b1) begin fails++; $display("FAIL soft_acks: got %b want 1", ok); end
    if (vsync !== 1'b1) begin fails++; $display("FAIL soft_vsync: got %b want 1", vsync); end
    k = 0;
    while (vsync && k < 4 * LINE) begin sample(); k++; end
    k = 0;
    while (!href && k < 20 * LINE) begin sample(); k++; end
    tests++;
    if (k != VB * LINE) begin fails++; $display("FAIL soft_href_gap: got %0d want %0d", k, VB * LINE); end
    rd_reg(8'h12, d);
    tests++;
    if (d !== 8'h00) begin fails++; $display("FAIL com7_clear: got %h want 00", d); end
    rd_reg(8'h30, d);
    tests++;
    if (d !== 8'h00) begin fails++; $display("FAIL soft_r30: got %h want 00", d); end
    rd_reg(8'h1D, d);
    tests++;
    if (d !== 8'hA2) begin fails++; $display("FAIL soft_midl: got %h want a2", d); end
  endtask
  task automatic test_mid_reset();
    int vs_len = -1, href_at = -1;
    wait_line20();
    @(negedge xclk);
    reset = 1'b1;
    @(negedge xclk);
    tests += 4;
    if (p_clock !== 1'b0) begin fails++; $display("FAIL mid_pclk: got %b want 0", p_clock); end
    if (vsync !== 1'b0) begin fails++; $display("FAIL mid_vsync: got %b want 0", vsync); end
    if (href !== 1'b0) begin fails++; $display("FAIL mid_href: got %b want 0", href); end
    if (p_data !== 8'h00) begin fails++; $display("FAIL mid_pdata: got %h want 00", p_data); end
    repeat (3) @(negedge xclk);
    reset = 1'b0;
    sample();
    for (int n = 0; n <= A && href_at < 0; n++) begin
      sample();
      if (!vsync && vs_len < 0) vs_len = n;
      if (href && href_at < 0) href_at = n;
    end
    tests += 2;
    if (vs_len != 3 * LINE) begin fails++; $display("FAIL mid_vsync_len: got %0d want %0d", vs_len, 3 * LINE); end
    if (href_at != A) begin fails++; $display("FAIL mid_first_href: got %0d want %0d", href_at, A); end
  endtask
  initial begin
    test_reset();
    test_video();
    test_id_read();
    test_bad_addr();
    test_ro_write();
    test_auto_inc();
    test_partial();
    test_soft_reset();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
